rtc_access_sched: RTL and testbench

RTC_ACCESS_SCHED -- requirements
Module: rtc_access_sched

---
 rtl/rtc_sched_pkg.sv | 7 +
 rtl/rtc_sched_timer.sv | 15 +
 rtl/rtc_access_sched.sv | 79 +++++++
 tb/tb_rtc_access_sched.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rtc_sched_pkg.sv
// rtc_sched_pkg: shared state encoding, bus owner codes and transaction length default for the RTC access scheduler
package rtc_sched_pkg;
  typedef enum logic [1:0] {IDLE, RD_ACTIVE, WR_ACTIVE} state_t;
  localparam logic [2:0] OWNER_NONE = 3'd0;
  localparam logic [2:0] OWNER_WR = 3'd7;
  localparam int TXN_CYCLES_DEF = 35;
endpackage

// File: rtl/rtc_sched_timer.sv
// rtc_sched_timer: free-running refresh timer, one-cycle wrap pulse on its last count
module rtc_sched_timer #(
  parameter int PERIOD = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic wrap
);
  localparam int W = PERIOD > 1 ? $clog2(PERIOD) : 1;
  logic [W-1:0] cnt;
  assign wrap = cnt == W'(PERIOD - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= wrap ? '0 : cnt + W'(1);
endmodule

// File: rtl/rtc_access_sched.sv
// rtc_access_sched: arbitrates the RTC bus between periodic field-read sweeps and user writes (optional sweep_hold via RTC_SCHED_HOLD_EN)
module rtc_access_sched
  import rtc_sched_pkg::*;
#(
  parameter int NUM_FIELDS = 6,
  parameter int TXN_CYCLES = TXN_CYCLES_DEF,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
`ifdef RTC_SCHED_HOLD_EN
  input  logic                  sweep_hold,
`endif
  output logic [NUM_FIELDS-1:0] rd_start,
  output logic                  wr_start,
  output logic [2:0]            bus_owner,
  output logic                  wr_ack,
  output logic                  sweep_done,
  output logic                  busy
);
  localparam int CW = $clog2(TXN_CYCLES);
  localparam logic [2:0] LASTF = 3'(NUM_FIELDS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] field, field_n;
  logic sweep_pend, intr, intr_n, take, wrap, last, hold;
`ifdef RTC_SCHED_HOLD_EN
  assign hold = sweep_hold;
`else
  assign hold = 1'b0;
`endif
  rtc_sched_timer #(.PERIOD(REFRESH_CYCLES)) u_timer (.clk(clk), .reset(reset), .wrap(wrap));
  assign last = cnt == CW'(TXN_CYCLES - 1);
  // A wrap seen at the decision point is consumed directly so it does not queue a second sweep
  always_comb begin
    state_n = state;
    field_n = field;
    intr_n = intr;
    take = 1'b0;
    if (state != IDLE && !last) state_n = state;
    else if (state == RD_ACTIVE && field != LASTF) begin
      field_n = field + 3'd1;
      state_n = wr_req ? WR_ACTIVE : RD_ACTIVE;
      intr_n = wr_req;
    end
    else if (wr_req) state_n = WR_ACTIVE;
    else if (intr && !hold) begin
      state_n = RD_ACTIVE;
      intr_n = 1'b0;
    end
    else if ((sweep_pend || wrap) && !hold) begin
      state_n = RD_ACTIVE;
      field_n = '0;
      take = 1'b1;
    end
    else state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      field <= '0;
      intr <= 1'b0;
      sweep_pend <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || last) ? '0 : cnt + CW'(1);
      field <= field_n;
      intr <= intr_n;
      sweep_pend <= take ? 1'b0 : (wrap || sweep_pend);
    end
  assign rd_start = (state == RD_ACTIVE && cnt == '0) ? NUM_FIELDS'(1) << field : '0;
  assign wr_start = state == WR_ACTIVE && cnt == '0;
  assign wr_ack = state == WR_ACTIVE && last;
  assign sweep_done = state == RD_ACTIVE && last && field == LASTF;
  assign bus_owner = state == RD_ACTIVE ? field + 3'd1 : state == WR_ACTIVE ? OWNER_WR : OWNER_NONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_rtc_access_sched.sv
// tb_rtc_access_sched: directed-vector bench; main DUT with REFRESH_CYCLES=300, second DUT with 100 for sweep collapsing
module tb_rtc_access_sched;
  logic clk = 1'b0;
  logic reset, wr_req, reset2;
  logic [5:0] rd_start, rd_start2;
  logic wr_start, wr_ack, sweep_done, busy;
  logic wr_start2, wr_ack2, sweep_done2, busy2;
  logic [2:0] bus_owner, bus_owner2;
  int cyc, cyc2, n_vec, n_err, c;
  logic done2 = 1'b0;
`ifdef RTC_SCHED_HOLD_EN
  logic sweep_hold = 1'b0;
  logic no_hold = 1'b0;
`endif
  always #5 clk = ~clk;
  rtc_access_sched #(.NUM_FIELDS(6), .TXN_CYCLES(35), .REFRESH_CYCLES(300)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req),
`ifdef RTC_SCHED_HOLD_EN
    .sweep_hold(sweep_hold),
`endif
    .rd_start(rd_start), .wr_start(wr_start), .bus_owner(bus_owner),
    .wr_ack(wr_ack), .sweep_done(sweep_done), .busy(busy));
  rtc_access_sched #(.NUM_FIELDS(6), .TXN_CYCLES(35), .REFRESH_CYCLES(100)) dut2 (
    .clk(clk), .reset(reset2), .wr_req(1'b0),
`ifdef RTC_SCHED_HOLD_EN
    .sweep_hold(no_hold),
`endif
    .rd_start(rd_start2), .wr_start(wr_start2), .bus_owner(bus_owner2),
    .wr_ack(wr_ack2), .sweep_done(sweep_done2), .busy(busy2));
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  always @(posedge clk) cyc2 <= reset2 ? 0 : cyc2 + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic ev(input int sel, input int k);
    return sel == 0 ? rd_start[k] : sel == 1 ? wr_start : sel == 2 ? wr_ack : sweep_done;
  endfunction
  task automatic wait_ev(input int sel, input int k, output int at);
    at = -1;
    for (int i = 0; i < 3000; i++) begin
      if (ev(sel, k)) begin
        at = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask
  task automatic until_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  initial begin
    int d1, d2, r1, n0;
    d1 = -1; d2 = -1; r1 = -1; n0 = 0;
    reset2 = 1'b1;
    repeat (3) @(negedge clk);
    reset2 = 1'b0;
    for (int i = 0; i < 520; i++) begin
      if (sweep_done2) begin
        if (d1 < 0) d1 = cyc2;
        else if (d2 < 0) d2 = cyc2;
      end
      if (rd_start2[0]) begin
        n0++;
        if (n0 == 2) r1 = cyc2;
      end
      @(negedge clk);
    end
    check("fast_done1", d1, 309);
    check("fast_resweep_start", r1, 310);
    check("fast_done2", d2, 519);
    check("fast_sweep_count", n0, 2);
    done2 = 1'b1;
  end
  initial begin
    int nb;
    n_vec = 0; n_err = 0;
    reset = 1'b1; wr_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_outputs", int'({rd_start, wr_start, bus_owner, wr_ack, sweep_done, busy}), 0);
    wait_ev(0, 0, c); check("first_rd0", c, 300);
    check("owner_f0", int'(bus_owner), 1);
    wait_ev(0, 1, c); check("first_rd1", c, 335);
    wait_ev(0, 5, c); check("first_rd5", c, 475);
    wait_ev(3, 0, c); check("first_done", c, 509);
    @(negedge clk);
    check("idle_after_sweep", int'(busy), 0);
    until_cyc(599);
    wr_req = 1'b1;
    wait_ev(1, 0, c); check("tie_wr_start", c, 600);
    wr_req = 1'b0;
    check("owner_wr", int'(bus_owner), 7);
    wait_ev(2, 0, c); check("tie_wr_ack", c, 634);
    wait_ev(0, 0, c); check("tie_rd0", c, 635);
    wait_ev(0, 2, c); check("intr_rd2", c, 705);
    wr_req = 1'b1;
    wait_ev(1, 0, c); check("intr_wr_start", c, 740);
    wr_req = 1'b0;
    wait_ev(2, 0, c); check("intr_wr_ack", c, 774);
    wait_ev(0, 3, c); check("resume_rd3", c, 775);
    check("owner_f3", int'(bus_owner), 4);
    wait_ev(3, 0, c); check("intr_done", c, 879);
    @(negedge clk);
    wr_req = 1'b1;
    wait_ev(1, 0, c); check("b2b_wr1", c, 881);
    wait_ev(2, 0, c); check("b2b_ack1", c, 915);
    wait_ev(1, 0, c); check("b2b_wr2", c, 916);
    wr_req = 1'b0;
    wait_ev(0, 0, c); check("pend_after_wr", c, 951);
    wait_ev(0, 4, c); check("rst_rd4", c, 1091);
    repeat (17) @(negedge clk);
    check("owner_f4", int'(bus_owner), 5);
    reset = 1'b1;
    #1;
    check("midtxn_reset", int'({rd_start, wr_start, bus_owner, wr_ack, sweep_done, busy}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nb = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy) nb++;
      @(negedge clk);
    end
    check("no_resume_busy", nb, 0);
    wait_ev(0, 0, c); check("post_reset_rd0", c, 300);
`ifdef RTC_SCHED_HOLD_EN
    begin
      int nrd, ws;
      nrd = 0; ws = -1;
      wait_ev(3, 0, c); check("hold_pre_done", c, 509);
      until_cyc(520);
      sweep_hold = 1'b1;
      while (cyc < 700) begin
        if (cyc == 610) wr_req = 1'b1;
        if (wr_start) begin
          wr_req = 1'b0;
          ws = cyc;
        end
        if (rd_start != '0) nrd++;
        @(negedge clk);
      end
      check("hold_wr_start", ws, 611);
      check("hold_no_rd", nrd, 0);
      sweep_hold = 1'b0;
      wait_ev(0, 0, c); check("hold_release_rd0", c, 701);
    end
`endif
    for (int i = 0; i < 2000 && !done2; i++) @(negedge clk);
    check("fast_dut_finished", int'(done2), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
